// File: rtl/lpc_uart_formatter.sv
// Buffers decoded LPC cycle records and renders each one as an 11-byte ASCII line
// ("W 0080 5A\r\n") streamed byte by byte into uart_tx via its enable/ready handshake.
module lpc_uart_formatter #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_dir,
    input  logic [15:0] in_addr,
    input  logic [7:0]  in_data,
    output logic [7:0]  uart_data,
    output logic        uart_enable,
    input  logic        uart_ready,
    output logic [7:0]  drop_count,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [24:0] mem [DEPTH];
    logic [24:0] line_q;
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, push, pop, accept;
    logic        ready_q;
    logic [7:0]  drop_q;
    logic [7:0]  data_q;
    logic        enable_q, busy_q;
    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  chars [16];

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push   = in_valid && !full;
    assign pop    = (state_q == IDLE) && !empty;
    // uart_tx drops ready when it latches the pending byte
    assign accept = ready_q && !uart_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {in_dir, in_addr, in_data};
        end
    end

    always_ff @(posedge clock) begin
        if (pop) begin
            line_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    // Character table for the line currently held in line_q
    assign chars[0] = line_q[24] ? 8'h57 : 8'h52;
    assign chars[1] = 8'h20;
    assign chars[6] = 8'h20;
    assign chars[9] = 8'h0D;
    assign chars[10] = 8'h0A;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_addr_hex
            assign chars[2 + gi] = hex_char(line_q[23 - 4*gi -: 4]);
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_data_hex
            assign chars[7 + gi] = hex_char(line_q[7 - 4*gi -: 4]);
        end
        for (genvar gi = 11; gi < 16; gi++) begin : g_unused
            assign chars[gi] = 8'h00;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = SEND;
                    idx_d   = 4'd0;
                end
            end
            SEND: begin
                if (accept) begin
                    if (idx_q == 4'd10) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= 8'd0;
            ready_q  <= 1'b0;
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            data_q   <= 8'h00;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ready_q <= uart_ready;
            state_q <= state_d;
            idx_q   <= idx_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            // A pop in the same cycle does not rescue a record arriving while full
            if (in_valid && full && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            // Outputs trail the FSM by one edge, giving the dropout between lines
            enable_q <= (state_q == SEND);
            if (state_q == SEND) begin
                data_q <= chars[idx_q];
            end
            busy_q <= (state_q != IDLE) || !empty;
        end
    end

    assign uart_data   = data_q;
    assign uart_enable = enable_q;
    assign drop_count  = drop_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_lpc_uart_formatter.sv
// Directed bench for lpc_uart_formatter: a behavioural uart_tx model collects the
// emitted bytes, and the main sequence compares them to hand-computed lines.
module tb_lpc_uart_formatter;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_dir;
    logic [15:0] in_addr;
    logic [7:0]  in_data;
    logic [7:0]  uart_data;
    logic        uart_enable;
    logic        uart_ready;
    logic [7:0]  drop_count;
    logic        busy;

    int n_asserts = 0;
    int n_fail    = 0;
    int take_limit = 0;
    logic [7:0] got [$];

    logic [7:0] exp_w0080 [11] = '{8'h57, 8'h20, 8'h30, 8'h30, 8'h38, 8'h30, 8'h20, 8'h35, 8'h41, 8'h0D, 8'h0A};
    logic [7:0] exp_rabcd [11] = '{8'h52, 8'h20, 8'h41, 8'h42, 8'h43, 8'h44, 8'h20, 8'h45, 8'h46, 8'h0D, 8'h0A};

    lpc_uart_formatter #(.DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_dir     (in_dir),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .uart_data  (uart_data),
        .uart_enable(uart_enable),
        .uart_ready (uart_ready),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // uart_tx model: takes a byte when enabled and ready, then stays busy 4 cycles
    initial begin : uart_model
        int   hold;
        logic rs;
        hold = 0;
        uart_ready = 1'b1;
        forever begin
            @(posedge clock);
            rs = reset;
            #1;
            if (rs) begin
                uart_ready = 1'b1;
                hold = 0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) uart_ready = 1'b1;
            end else if (uart_ready && uart_enable && (got.size() < take_limit)) begin
                got.push_back(uart_data);
                uart_ready = 1'b0;
                hold = 4;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_rec(input logic [24:0] r);
        in_valid = 1'b1;
        {in_dir, in_addr, in_data} = r;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int c;
        c = 0;
        while ((got.size() < n) && (c < 3000)) begin
            step();
            c++;
        end
        check({tag, "_timeout"}, 32'(got.size() >= n), 32'd1);
    endtask

    function automatic logic [7:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 8'hxx;
    endfunction

    // Reference rendering of a record, via a string lookup of hex digits
    function automatic logic [7:0] exp_char(input logic [24:0] rec, input int i);
        string hx;
        hx = "0123456789ABCDEF";
        case (i)
            0:       return rec[24] ? "W" : "R";
            1, 6:    return " ";
            2:       return hx[int'(rec[23:20])];
            3:       return hx[int'(rec[19:16])];
            4:       return hx[int'(rec[15:12])];
            5:       return hx[int'(rec[11:8])];
            7:       return hx[int'(rec[7:4])];
            8:       return hx[int'(rec[3:0])];
            9:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    function automatic logic [24:0] ovf_rec(input int k);
        return {k[0], 16'h1234 + 16'(k) * 16'h1111, 8'h3C + 8'(k) * 8'h11};
    endfunction

    function automatic logic [24:0] sat_rec(input int k);
        return {~k[0], 16'hF00D - 16'(k), 8'(k * 7)};
    endfunction

    task automatic check_model_line(input int base, input logic [24:0] rec, input string tag);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(got_at(base + i)), 32'(exp_char(rec, i)));
        end
    endtask

    task automatic check_fixed_line(input logic [7:0] exp [11], input string tag);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(got_at(i)), 32'(exp[i]));
        end
    endtask

    initial begin : main
        int bad_data;
        int bad_en;
        reset = 1'b1;
        in_valid = 1'b0;
        in_dir = 1'b0;
        in_addr = 16'h0000;
        in_data = 8'h00;
        repeat (3) step();
        check("rst_enable", 32'(uart_enable), 32'd0);
        check("rst_data", 32'(uart_data), 32'h00);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // Single write, with record latency
        got.delete();
        take_limit = 1000;
        push_rec({1'b1, 16'h0080, 8'h5A});
        step();
        check("lat_enable_n1", 32'(uart_enable), 32'd0);
        step();
        check("lat_enable_n2", 32'(uart_enable), 32'd1);
        check("lat_data_n2", 32'(uart_data), 32'h57);
        wait_bytes(11, "w0080");
        check_fixed_line(exp_w0080, "w0080");
        repeat (8) step();
        check("w0080_enable_end", 32'(uart_enable), 32'd0);
        check("w0080_busy_end", 32'(busy), 32'd0);
        check("w0080_count", 32'(got.size()), 32'd11);

        // Read cycle with hex letters
        got.delete();
        push_rec({1'b0, 16'hABCD, 8'hEF});
        wait_bytes(11, "rabcd");
        check_fixed_line(exp_rabcd, "rabcd");
        repeat (8) step();
        check("rabcd_count", 32'(got.size()), 32'd11);

        // Overflow: r0 in the line register, r1..r4 queued, r5/r6 dropped
        take_limit = 0;
        got.delete();
        for (int k = 0; k < 7; k++) push_rec(ovf_rec(k));
        step();
        check("ovf_drop", 32'(drop_count), 32'd2);
        check("ovf_busy", 32'(busy), 32'd1);
        check("ovf_enable", 32'(uart_enable), 32'd1);
        check("ovf_data_r0", 32'(uart_data), 32'h52);
        take_limit = 1000;
        wait_bytes(55, "ovf");
        for (int j = 0; j < 5; j++) check_model_line(11 * j, ovf_rec(j), $sformatf("ovf_r%0d", j));
        repeat (10) step();
        check("ovf_count", 32'(got.size()), 32'd55);
        check("ovf_drop_after", 32'(drop_count), 32'd2);
        check("ovf_busy_end", 32'(busy), 32'd0);

        // Stall 1000 cycles while byte 4 (0x38) is pending
        got.delete();
        take_limit = 4;
        push_rec({1'b1, 16'h0080, 8'h5A});
        wait_bytes(4, "stall_pre");
        repeat (6) step();
        bad_data = 0;
        bad_en = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (uart_data !== 8'h38) bad_data++;
            if (uart_enable !== 1'b1) bad_en++;
        end
        check("stall_data_changes", 32'(bad_data), 32'd0);
        check("stall_enable_drops", 32'(bad_en), 32'd0);
        check("stall_data", 32'(uart_data), 32'h38);
        take_limit = 1000;
        wait_bytes(11, "stall");
        check_fixed_line(exp_w0080, "stall");
        repeat (10) step();
        check("stall_count", 32'(got.size()), 32'd11);

        // Reset mid-line with two records queued
        got.delete();
        take_limit = 3;
        for (int k = 0; k < 3; k++) push_rec(ovf_rec(k));
        wait_bytes(3, "rstmid_pre");
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstmid_enable", 32'(uart_enable), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_drop", 32'(drop_count), 32'd0);
        repeat (10) step();
        check("rstmid_flushed_busy", 32'(busy), 32'd0);
        check("rstmid_flushed_enable", 32'(uart_enable), 32'd0);
        got.delete();
        take_limit = 1000;
        push_rec({1'b0, 16'hABCD, 8'hEF});
        wait_bytes(11, "rstmid_new");
        check_fixed_line(exp_rabcd, "rstmid_new");
        repeat (10) step();
        check("rstmid_count", 32'(got.size()), 32'd11);

        // Saturation: 305 records into a stalled formatter, 300 dropped
        take_limit = 0;
        got.delete();
        for (int k = 0; k < 305; k++) push_rec(sat_rec(k));
        step();
        check("sat_drop", 32'(drop_count), 32'd255);
        take_limit = 1000;
        wait_bytes(55, "sat");
        for (int j = 0; j < 5; j++) check_model_line(11 * j, sat_rec(j), $sformatf("sat_r%0d", j));
        repeat (10) step();
        check("sat_count", 32'(got.size()), 32'd55);
        check("sat_drop_after", 32'(drop_count), 32'd255);
        check("sat_busy_end", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/lpc_uart_formatter.md
# lpc_uart_formatter

Sits directly upstream of `uart_tx`. Accepts decoded LPC cycle records (direction, 16-bit address, 8-bit data) from the sniffer core into a small record FIFO. Renders each record as an 11-byte ASCII line and feeds it one byte at a time into `uart_tx` through that block's enable/ready handshake. It isolates the bursty LPC capture path from the slow serial output and counts records lost to overflow.

## Interface
- `DEPTH`, 4: record FIFO depth in entries; must be a power of two, at least 2.
- `clock`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  one-cycle strobe; a record is present on `in_dir`/`in_addr`/`in_data`.
- `in_dir`  input  1  1 = write cycle ('W'), 0 = read cycle ('R').
- `in_addr`  input  16  LPC address.
- `in_data`  input  8  LPC data byte.
- `uart_data`  output  8  byte presented to `uart_tx` `read_data`.
- `uart_enable`  output  1  drives `uart_tx` `read_clock_enable`; high while a byte is pending.
- `uart_ready`  input  1  `uart_tx` `ready`; a 1→0 transition means the pending byte was taken.
- `drop_count`  output  8  saturating count of records dropped because the FIFO was full.
- `busy`  output  1  high when the FIFO is non-empty or a line is in progress.

## Operation
- **Line format:** dir char, 0x20, four uppercase hex address nibbles (MSB first), 0x20, two uppercase hex data nibbles, 0x0D, 0x0A. Byte index runs 0..10.
- **Hex encoding:** nibble 0–9 → 0x30+n; nibble A–F → 0x41+(n−10).
- **FIFO:**
  - Entry is 25 bits {dir, addr, data]. Read/write pointers are log2(DEPTH)+1 bits, so full and empty are distinguished by the MSB.
  - Push when `in_valid` and not full.
  - When `in_valid` arrives while full, the record is discarded and `drop_count` increments, saturating at 255. This holds even if a pop happens in the same cycle.
- **Accept detect:** `ready_q` registers `uart_ready`. `accept = ready_q & ~uart_ready`.
- **FSM:**
  - **IDLE:** `uart_enable` = 0. If the FIFO is non-empty, pop the head into the line register, set idx = 0, and go to SEND.
  - **SEND:** `uart_enable` = 1 and `uart_data` = char(idx). On `accept`:
    - if idx = 10, go to IDLE;
    - otherwise idx + 1, and `uart_data` updates on the next edge.
  - While no accept occurs, `uart_data` and `uart_enable` hold stable indefinitely.
- **`busy`** = (state ≠ IDLE) | ~empty, registered.

## Timing
- **Reset values:** `uart_enable` 0, `uart_data` 0x00, `drop_count` 0, `busy` 0, `ready_q` 0, FIFO empty, state IDLE, idx 0.
- **Reset mid-line:** the line is abandoned and the FIFO is flushed. `uart_enable` is low in the first cycle after reset is sampled.
- **Record latency (FSM idle, FIFO empty):**
  - `in_valid` at edge N writes the FIFO.
  - IDLE pops at edge N+1.
  - `uart_enable` = 1 with `uart_data` = dir char after edge N+2.
- **Byte advance:** `accept` is seen one cycle after `uart_ready` falls (registered edge). The new `uart_data` is visible on the following edge, so there is exactly one cycle of old data after detection.
- **Between lines:** `uart_enable` drops for at least one cycle (IDLE), even when the FIFO holds further records.
- **Capacity:** effective buffering is DEPTH records plus the one line in progress.
- **Reset vs. `accept`:** `uart_ready` falling while in IDLE, or coincident with reset, is ignored.

## Test plan
- **Single write:** `in_valid` with dir=1, addr=0x0080, data=0x5A; model `uart_tx` accepts each byte. Output sequence is 57 20 30 30 38 30 20 35 41 0D 0A, then `uart_enable` = 0 and `busy` = 0.
- **Read, hex letters:** dir=0, addr=0xABCD, data=0xEF. Output is 52 20 41 42 43 44 20 45 46 0D 0A.
- **Overflow (DEPTH=4):** hold `uart_ready` high (no accept) and strobe 7 records on consecutive cycles r0..r6. Result: `drop_count` = 2 (r5, r6 dropped). After releasing the model, exactly r0..r4 are emitted in order.
- **Stall hold:** keep `uart_ready` high for 1000 cycles mid-line at idx=4. `uart_data` stays 0x38 and `uart_enable` stays 1 throughout; there is no skipped or repeated byte afterwards.
- **Reset mid-line:** assert reset for 1 cycle after the 3rd byte is accepted, with 2 records queued.
  - Next cycle: `uart_enable` = 0, `busy` = 0, `drop_count` = 0.
  - A new record afterwards is emitted from byte 0 in full.
- **Saturation:** with the model stalled, push 300 records into a full FIFO. `drop_count` stops at 255, and queued lines remain intact.
